// File: rtl/ppg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : ppg                                                              |
// | Brief    : Radix-4 Booth partial-product generator, signed 8x8 MAC lane.    |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
module ppg (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  multiplicand,
  input  logic [7:0]  multiplier,
  output logic [10:0] pp0,
  output logic [8:0]  pp1,
  output logic [8:0]  pp2,
  output logic [8:0]  pp3,
  output logic        neg0,
  output logic        neg1,
  output logic        neg2,
  output logic        neg3,
  output logic [10:0] pp0_q,
  output logic [8:0]  pp1_q,
  output logic [8:0]  pp2_q,
  output logic [8:0]  pp3_q,
  output logic        neg0_q,
  output logic        neg1_q,
  output logic        neg2_q,
  output logic        neg3_q
);

  // Returns {neg, P}; negative digits use one's complement, the +1 goes out on neg.
  function automatic logic [9:0] booth_sel(input logic [2:0] grp,
                                           input logic [8:0] m1,
                                           input logic [8:0] m2);
    logic [9:0] r;
    r = 10'h000;
    case (grp)
      3'b001, 3'b010: r = {1'b0, m1};
      3'b011:         r = {1'b0, m2};
      3'b100:         r = {1'b1, ~m2};
      3'b101, 3'b110: r = {1'b1, ~m1};
      default:        r = 10'h000;
    endcase
    return r;
  endfunction

  logic [8:0] w_m1;
  logic [8:0] w_m2;
  logic [8:0] w_y_ext;
  logic [8:0] w_p [4];
  logic [3:0] w_neg;

  assign w_m1    = {multiplicand[7], multiplicand};
  assign w_m2    = {multiplicand, 1'b0};
  assign w_y_ext = {multiplier, 1'b0};

  for (genvar i = 0; i < 4; i++) begin : g_booth
    assign {w_neg[i], w_p[i]} = booth_sel(w_y_ext[2*i+2 -: 3], w_m1, w_m2);
  end

  // Inverted-sign encoding removes the need for sign extension in the compressor.
  assign pp0  = {~w_p[0][8], w_p[0][8], w_p[0]};
  assign pp1  = {~w_p[1][8], w_p[1][7:0]};
  assign pp2  = {~w_p[2][8], w_p[2][7:0]};
  assign pp3  = {~w_p[3][8], w_p[3][7:0]};
  assign neg0 = w_neg[0];
  assign neg1 = w_neg[1];
  assign neg2 = w_neg[2];
  assign neg3 = w_neg[3];

  always_ff @(posedge clk) begin
    if (reset) begin
      pp0_q  <= 11'h000;
      pp1_q  <= 9'h000;
      pp2_q  <= 9'h000;
      pp3_q  <= 9'h000;
      neg0_q <= 1'b0;
      neg1_q <= 1'b0;
      neg2_q <= 1'b0;
      neg3_q <= 1'b0;
    end else begin
      pp0_q  <= pp0;
      pp1_q  <= pp1;
      pp2_q  <= pp2;
      pp3_q  <= pp3;
      neg0_q <= neg0;
      neg1_q <= neg1;
      neg2_q <= neg2;
      neg3_q <= neg3;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ppg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : tb_ppg                                                           |
// | Brief    : Scoreboard bench for the Booth partial-product generator.        |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
module tb_ppg;

  localparam logic [1:0] MODE_COMB = 2'd0;
  localparam logic [1:0] MODE_SUM  = 2'd1;
  localparam logic [1:0] MODE_Q    = 2'd2;

  typedef struct {
    logic [1:0]  mode;
    logic [10:0] pp0;
    logic [8:0]  pp1;
    logic [8:0]  pp2;
    logic [8:0]  pp3;
    logic [3:0]  neg;
    logic [16:0] sum;
  } item_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  multiplicand = 8'h00;
  logic [7:0]  multiplier = 8'h00;
  logic [10:0] pp0, pp0_q;
  logic [8:0]  pp1, pp2, pp3, pp1_q, pp2_q, pp3_q;
  logic        neg0, neg1, neg2, neg3, neg0_q, neg1_q, neg2_q, neg3_q;

  int n_tests = 0;
  int n_fail  = 0;
  item_t sb[$];

  ppg dut (
    .clk(clk), .reset(reset),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .pp0(pp0), .pp1(pp1), .pp2(pp2), .pp3(pp3),
    .neg0(neg0), .neg1(neg1), .neg2(neg2), .neg3(neg3),
    .pp0_q(pp0_q), .pp1_q(pp1_q), .pp2_q(pp2_q), .pp3_q(pp3_q),
    .neg0_q(neg0_q), .neg1_q(neg1_q), .neg2_q(neg2_q), .neg3_q(neg3_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [18:0] act, input logic [18:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (M=%0d Y=%0d)", name, act, exp,
               $signed(multiplicand), $signed(multiplier));
    end
  endtask

  function automatic logic [16:0] recon(input logic [10:0] a, input logic [8:0] b,
                                        input logic [8:0] c, input logic [8:0] d,
                                        input logic [3:0] n);
    logic [18:0] s;
    s = 19'(a) + (19'(b) << 2) + (19'(c) << 4) + (19'(d) << 6)
      + 19'(n[0]) + (19'(n[1]) << 2) + (19'(n[2]) << 4) + (19'(n[3]) << 6) + 19'h7A800;
    return s[16:0];
  endfunction

  // Monitor: one scoreboard entry is consumed per falling edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      item_t it;
      it = sb.pop_front();
      if (it.mode == MODE_COMB) begin
        check("pp0", 19'(pp0), 19'(it.pp0));
        check("pp1", 19'(pp1), 19'(it.pp1));
        check("pp2", 19'(pp2), 19'(it.pp2));
        check("pp3", 19'(pp3), 19'(it.pp3));
        check("neg", 19'({neg3, neg2, neg1, neg0}), 19'(it.neg));
        check("sum", 19'(recon(pp0, pp1, pp2, pp3, {neg3, neg2, neg1, neg0})), 19'(it.sum));
      end else if (it.mode == MODE_SUM) begin
        check("sweep_sum", 19'(recon(pp0, pp1, pp2, pp3, {neg3, neg2, neg1, neg0})), 19'(it.sum));
      end else begin
        check("pp0_q", 19'(pp0_q), 19'(it.pp0));
        check("pp1_q", 19'(pp1_q), 19'(it.pp1));
        check("pp2_q", 19'(pp2_q), 19'(it.pp2));
        check("pp3_q", 19'(pp3_q), 19'(it.pp3));
        check("neg_q", 19'({neg3_q, neg2_q, neg1_q, neg0_q}), 19'(it.neg));
      end
    end
  end

  function automatic item_t mk(input logic [1:0] mode, input logic [10:0] a, input logic [8:0] b,
                               input logic [8:0] c, input logic [8:0] d, input logic [3:0] n,
                               input logic [16:0] s);
    item_t it;
    it.mode = mode; it.pp0 = a; it.pp1 = b; it.pp2 = c; it.pp3 = d; it.neg = n; it.sum = s;
    return it;
  endfunction

  task automatic drive(input logic r, input logic [7:0] m, input logic [7:0] y);
    @(posedge clk);
    #1;
    reset = r;
    multiplicand = m;
    multiplier = y;
  endtask

  initial begin
    item_t zq, q35, q1m1;
    zq   = mk(MODE_Q, 11'h000, 9'h000, 9'h000, 9'h000, 4'h0, 17'h0);
    q35  = mk(MODE_Q, 11'h403, 9'h103, 9'h100, 9'h100, 4'h0, 17'h0);
    q1m1 = mk(MODE_Q, 11'h3FE, 9'h100, 9'h100, 9'h100, 4'h1, 17'h0);

    // Reset behaviour and registered-copy latency.
    drive(1'b1, 8'd3, 8'd5);
    sb.push_back(mk(MODE_COMB, 11'h403, 9'h103, 9'h100, 9'h100, 4'h0, 17'd15));
    drive(1'b1, 8'd3, 8'd5);  sb.push_back(zq);
    drive(1'b0, 8'd3, 8'd5);  sb.push_back(zq);
    drive(1'b0, 8'd3, 8'd5);  sb.push_back(q35);
    drive(1'b1, 8'd3, 8'd5);  sb.push_back(q35);
    drive(1'b0, 8'd3, 8'd5);  sb.push_back(zq);
    drive(1'b0, 8'd1, 8'hFF); sb.push_back(q35);
    drive(1'b0, 8'd1, 8'hFF); sb.push_back(q1m1);

    // Directed combinational vectors.
    drive(1'b0, 8'd1, 8'hFF);
    sb.push_back(mk(MODE_COMB, 11'h3FE, 9'h100, 9'h100, 9'h100, 4'h1, 17'h1FFFF));
    drive(1'b0, 8'h80, 8'h80);
    sb.push_back(mk(MODE_COMB, 11'h400, 9'h100, 9'h100, 9'h1FF, 4'h8, 17'h04000));
    drive(1'b0, 8'h80, 8'h01);
    sb.push_back(mk(MODE_COMB, 11'h380, 9'h100, 9'h100, 9'h100, 4'h0, 17'h1FF80));
    drive(1'b0, 8'h80, 8'hFF);
    sb.push_back(mk(MODE_COMB, 11'h47F, 9'h100, 9'h100, 9'h100, 4'h1, 17'h00080));
    drive(1'b0, 8'd5, 8'd2);
    sb.push_back(mk(MODE_COMB, 11'h3F5, 9'h105, 9'h100, 9'h100, 4'h1, 17'h0000A));
    drive(1'b0, 8'hFF, 8'd6);
    sb.push_back(mk(MODE_COMB, 11'h401, 9'h0FE, 9'h100, 9'h100, 4'h1, 17'h1FFFA));

    // Exhaustive operand sweep against the signed product.
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 256; b++) begin
        logic [7:0] ma, yb;
        int p;
        ma = 8'(a);
        yb = 8'(b);
        p = $signed(ma) * $signed(yb);
        drive(1'b0, ma, yb);
        sb.push_back(mk(MODE_SUM, 11'h0, 9'h0, 9'h0, 9'h0, 4'h0, p[16:0]));
      end
    end

    @(posedge clk);
    @(posedge clk);
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
